ibex_rvfi_trace_buffer: RTL and testbench

On-chip capture buffer for RVFI retirement records, the successor to the simulation-only tracer. It sits beside ibex_core on the RVFI outputs and stores a reduced record per retired instruction in a parametrised RAM. It supports two modes: streaming FIFO, and triggered circular capture with a programmable post-trigger count. Stored records drain through a valid/ready read port for a debug module or bus-side reader.

---
 rtl/ibex_rvfi_trace_buffer.sv | 126 ++++++++++++
 tb/tb_ibex_rvfi_trace_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer: on-chip RVFI retirement capture buffer with stream FIFO and triggered circular capture modes
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rvfi_*_i                       retirement record from ibex_core
//   mode_i, arm_i, clear_i         control (mode and post_cnt_i latched at arm)
//   trig_pc_i, post_cnt_i          trigger PC and records kept after the trigger
//   rec_valid_o/rec_ready_i/rec_data_o  record read port
//   level_o, state_o, drop_cnt_o   status
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth      = 16,
    parameter int unsigned CntWidth   = 16,
    parameter bit          TrigOnTrap = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rvfi_valid_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic [1:0]                 rvfi_mode_i,
    input  logic                       rvfi_trap_i,
    input  logic                       rvfi_intr_i,
    input  logic                       mode_i,
    input  logic                       arm_i,
    input  logic                       clear_i,
    input  logic [31:0]                trig_pc_i,
    input  logic [CntWidth-1:0]        post_cnt_i,
    output logic                       rec_valid_o,
    input  logic                       rec_ready_i,
    output logic [104:0]               rec_data_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic [1:0]                 state_o,
    output logic [CntWidth-1:0]        drop_cnt_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, POST = 2'd2, FROZEN = 2'd3} state_e;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CntWidth-1:0] post_q, post_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [CntWidth-1:0] drop_q, drop_d;
    logic [104:0]        mem [Depth];

    logic full, wr_req, pop, stream_drop, do_wr, ovw, trig;

    assign full        = level_q == LvlW'(Depth);
    assign wr_req      = rvfi_valid_i && (state_q == RUN || state_q == POST) && !clear_i;
    assign pop         = rec_valid_o && rec_ready_i && !clear_i;
    // A full stream FIFO only accepts a write when a pop frees a slot in the same cycle.
    assign stream_drop = !mode_q && full && !pop;
    assign do_wr       = wr_req && !stream_drop;
    // Capture mode keeps the newest Depth records: overwrite the oldest and drag rd along.
    assign ovw         = mode_q && full && do_wr;
    assign trig        = mode_q && state_q == RUN && do_wr &&
                         (rvfi_pc_rdata_i == trig_pc_i || (TrigOnTrap && rvfi_trap_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arm_i ? RUN : IDLE;
            RUN:     state_d = trig ? ((post_q == '0) ? FROZEN : POST) : RUN;
            POST:    state_d = (do_wr && cnt_q == CntWidth'(1)) ? FROZEN : POST;
            default: state_d = FROZEN;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_comb begin
        state_o     = state_q;
        rec_valid_o = (level_q != '0) && (!mode_q || state_q == FROZEN);
        rec_data_o  = (level_q != '0) ? mem[rd_ptr_q] : '0;
        level_o     = level_q;
        drop_cnt_o  = drop_q;
    end

    always_comb begin
        mode_d   = (state_q == IDLE && arm_i && !clear_i) ? mode_i : mode_q;
        post_d   = (state_q == IDLE && arm_i && !clear_i) ? post_cnt_i : post_q;
        cnt_d    = trig ? post_q : (state_q == POST && do_wr) ? cnt_q - CntWidth'(1) : cnt_q;
        wr_ptr_d = clear_i ? '0 : do_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = clear_i ? '0 : (pop || ovw) ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = clear_i ? '0 : level_q + LvlW'(do_wr && !ovw) - LvlW'(pop);
        drop_d   = clear_i ? '0 : (wr_req && stream_drop && !(&drop_q)) ? drop_q + CntWidth'(1) : drop_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= 1'b0;
            post_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            mode_q   <= mode_d;
            post_q   <= post_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= {rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i, rvfi_rd_addr_i,
                              rvfi_mode_i, rvfi_trap_i, rvfi_intr_i};
        end
    end
endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// tb_ibex_rvfi_trace_buffer: directed plus randomized checks of the trace buffer against a queue model
module tb_ibex_rvfi_trace_buffer;
    localparam int Depth = 4;
    localparam int CntW  = 4;

    logic clk = 1'b0, rst_ni = 1'b0;
    logic rvfi_valid_i = 0, rvfi_trap_i = 0, rvfi_intr_i = 0;
    logic [31:0] rvfi_pc_rdata_i = 0, rvfi_insn_i = 0, rvfi_rd_wdata_i = 0, trig_pc_i = 0;
    logic [4:0] rvfi_rd_addr_i = 0;
    logic [1:0] rvfi_mode_i = 0;
    logic mode_i = 0, arm_i = 0, clear_i = 0, rec_ready_i = 0;
    logic [CntW-1:0] post_cnt_i = 0;
    logic rec_valid_o;
    logic [104:0] rec_data_o;
    logic [2:0] level_o;
    logic [1:0] state_o;
    logic [CntW-1:0] drop_cnt_o;

    int checks = 0, errors = 0;

    logic [104:0] q[$];
    int m_st = 0, m_md = 0, m_post = 0, m_left = 0, m_drop = 0;

    ibex_rvfi_trace_buffer #(.Depth(Depth), .CntWidth(CntW), .TrigOnTrap(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
        .rvfi_insn_i(rvfi_insn_i), .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
        .rvfi_mode_i(rvfi_mode_i), .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i),
        .mode_i(mode_i), .arm_i(arm_i), .clear_i(clear_i), .trig_pc_i(trig_pc_i),
        .post_cnt_i(post_cnt_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_data_o(rec_data_o), .level_o(level_o), .state_o(state_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return q.size() != 0 && (m_md == 0 || m_st == 3);
    endfunction

    task automatic model_reset();
        q.delete();
        m_st = 0; m_md = 0; m_post = 0; m_left = 0; m_drop = 0;
    endtask

    task automatic model_step();
        logic [104:0] rec;
        bit pop, wr, full;
        rec = {rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i, rvfi_rd_addr_i, rvfi_mode_i, rvfi_trap_i, rvfi_intr_i};
        if (clear_i) begin
            q.delete(); m_st = 0; m_drop = 0;
            return;
        end
        full = q.size() == Depth;
        pop  = m_valid() && rec_ready_i;
        wr   = rvfi_valid_i && (m_st == 1 || m_st == 2);
        if (pop) void'(q.pop_front());
        if (wr) begin
            if (m_md == 0) begin
                if (full && !pop) m_drop = (m_drop == (1 << CntW) - 1) ? m_drop : m_drop + 1;
                else q.push_back(rec);
            end else begin
                q.push_back(rec);
                if (q.size() > Depth) void'(q.pop_front());
            end
        end
        if (m_st == 0 && arm_i) begin
            m_st = 1; m_md = mode_i; m_post = post_cnt_i;
        end else if (m_md == 1 && wr) begin
            if (m_st == 1 && (rvfi_pc_rdata_i == trig_pc_i || rvfi_trap_i)) begin
                m_left = m_post;
                m_st = (m_post == 0) ? 3 : 2;
            end else if (m_st == 2) begin
                m_left--;
                if (m_left == 0) m_st = 3;
            end
        end
    endtask

    task automatic tick();
        chk("state", state_o, m_st);
        chk("level", level_o, q.size());
        chk("valid", rec_valid_o, m_valid());
        chk("drop", drop_cnt_o, m_drop);
        chk("data", rec_data_o, q.size() != 0 ? q[0] : 105'd0);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input bit v, input logic [31:0] pc, input bit trap);
        rvfi_valid_i = v; rvfi_pc_rdata_i = pc; rvfi_trap_i = trap;
        rvfi_insn_i = $urandom; rvfi_rd_wdata_i = $urandom; rvfi_rd_addr_i = 5'($urandom);
        rvfi_mode_i = 2'($urandom); rvfi_intr_i = 1'($urandom);
    endtask

    task automatic do_clear();
        clear_i = 1; tick(); clear_i = 0;
    endtask

    task automatic arm(input bit md, input int post, input logic [31:0] tpc);
        mode_i = md; post_cnt_i = CntW'(post); trig_pc_i = tpc; arm_i = 1; tick(); arm_i = 0;
    endtask

    logic [31:0] cap_pcs[8] = '{32'h1F0, 32'h1F4, 32'h1F8, 32'h1FC, 32'h200, 32'h204, 32'h208, 32'h20C};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1;
        tick();
        // stream: three records, then ordered readout
        arm(0, 0, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) begin put(1, 32'h100 + 4 * i, 0); tick(); end
        put(0, 0, 0); tick();
        chk("s_level3", level_o, 3);
        rec_ready_i = 1;
        for (int i = 0; i < 3; i++) begin chk("s_pc", rec_data_o[104:73], 32'h100 + 4 * i); tick(); end
        rec_ready_i = 0; tick();
        // stream overflow
        for (int i = 0; i < 6; i++) begin put(1, 32'h300 + 4 * i, 0); tick(); end
        put(0, 0, 0); tick();
        chk("o_level", level_o, 4);
        chk("o_drop", drop_cnt_o, 2);
        chk("o_head", rec_data_o[104:73], 32'h300);
        put(1, 32'h3F0, 0); rec_ready_i = 1; tick();
        put(0, 0, 0); rec_ready_i = 0; tick();
        chk("o_level_wp", level_o, 4);
        chk("o_drop_wp", drop_cnt_o, 2);
        for (int i = 0; i < 20; i++) begin put(1, 32'h700, 0); tick(); end
        put(0, 0, 0); tick();
        chk("o_drop_sat", drop_cnt_o, 15);
        do_clear();
        // capture with post count 2
        arm(1, 2, 32'h200);
        for (int i = 0; i < 8; i++) begin put(1, cap_pcs[i], 0); tick(); end
        put(0, 0, 0); tick();
        chk("c_state", state_o, 3);
        rec_ready_i = 1;
        for (int i = 0; i < 4; i++) begin chk("c_pc", rec_data_o[104:73], cap_pcs[3 + i]); tick(); end
        chk("c_empty", rec_valid_o, 0);
        rec_ready_i = 0;
        do_clear();
        // capture, post 0, trap on second record
        arm(1, 0, 32'hFFFF_FFF0);
        put(1, 32'h400, 0); tick();
        put(1, 32'h404, 1); tick();
        put(1, 32'h408, 0); tick();
        put(0, 0, 0); tick();
        chk("t_state", state_o, 3);
        chk("t_level", level_o, 2);
        chk("t_head", rec_data_o[104:73], 32'h400);
        rec_ready_i = 1; repeat (3) tick(); rec_ready_i = 0;
        do_clear();
        // clear in POST beats a simultaneous write and arm
        arm(1, 3, 32'h500);
        put(1, 32'h4F0, 0); tick();
        put(1, 32'h500, 0); tick();
        chk("k_post", state_o, 2);
        put(1, 32'h504, 0); clear_i = 1; arm_i = 1; tick();
        clear_i = 0; arm_i = 0; put(0, 0, 0);
        chk("k_state", state_o, 0);
        chk("k_level", level_o, 0);
        tick();
        // async reset while in POST
        arm(1, 5, 32'h600);
        put(1, 32'h600, 0); tick();
        put(0, 0, 0); rec_ready_i = 1;
        #2 rst_ni = 0;
        #1;
        chk("r_state", state_o, 0);
        chk("r_level", level_o, 0);
        chk("r_valid", rec_valid_o, 0);
        chk("r_data", rec_data_o, 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1; rec_ready_i = 0;
        tick();
        // randomized sessions
        for (int r = 0; r < 30; r++) begin
            do_clear();
            arm(1'($urandom), $urandom_range(0, 5), 32'h100 + 4 * $urandom_range(0, 7));
            for (int c = 0; c < 40; c++) begin
                put(1'($urandom), 32'h100 + 4 * $urandom_range(0, 7), $urandom_range(0, 15) == 0);
                rec_ready_i = 1'($urandom);
                arm_i = $urandom_range(0, 19) == 0;
                tick();
            end
            put(0, 0, 0); arm_i = 0; rec_ready_i = 1;
            repeat (6) tick();
            rec_ready_i = 0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
